// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the main-memory bus initiator.
package mem_access_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 16;
  localparam int MEM_DEPTH_DEF = 16384;
  localparam int STAT_W        = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Width-parameterised up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the main memory (registered-read SRAM).
// Optional transaction counters are built when MEM_ACCESS_STATS_EN is defined.
import mem_access_pkg::*;

module mem_access_ctrl #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_ACCESS_STATS_EN
  output logic [STAT_W-1:0] stat_reads,
  output logic [STAT_W-1:0] stat_writes,
  output logic [STAT_W-1:0] stat_errs,
`endif
  output logic              busy
);

  // One extra bit so a depth equal to 2**ADDR_W does not truncate to zero.
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(MEM_DEPTH);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_accept;
  logic              w_oor;
  logic              w_rsp_hs;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;

  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_oor    = ({1'b0, req_addr} >= DEPTH_CMP);
  assign w_rsp_hs = (r_state == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_oor)          w_state_next = RESP;
          else if (req_write) w_state_next = WR;
          else                w_state_next = RD_ADDR;
        end
      end
      RD_ADDR: w_state_next = RD_DATA;
      RD_DATA: w_state_next = RESP;
      WR:      w_state_next = RESP;
      RESP:    if (rsp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Memory-side address/data are loaded at accept so they are already stable
  // in RD_ADDR/WR; an out-of-range request leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_accept) begin
        r_rsp_err   <= w_oor;
        r_rsp_rdata <= '0;
        if (!w_oor) begin
          r_mem_addr <= req_addr;
          if (req_write) begin
            r_mem_wdata <= req_wdata;
            r_mem_we    <= 1'b1;
          end
        end
      end
      if (r_state == RD_DATA) begin
        r_rsp_rdata <= mem_rdata;
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

`ifdef MEM_ACCESS_STATS_EN
  logic r_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_write <= req_write;
    end
  end

  sat_counter #(.W(STAT_W)) u_stat_reads (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_rsp_hs && !r_rsp_err && !r_write),
    .o_count (stat_reads)
  );

  sat_counter #(.W(STAT_W)) u_stat_writes (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_rsp_hs && !r_rsp_err && r_write),
    .o_count (stat_writes)
  );

  sat_counter #(.W(STAT_W)) u_stat_errs (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_rsp_hs && r_rsp_err),
    .o_count (stat_errs)
  );
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: registered-read memory device, reference array and
// randomized load/store traffic; counter checks are built with MEM_ACCESS_STATS_EN.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_errs;
`endif

  int nerr = 0;
  int nchk = 0;

  logic [15:0] mem_dev [0:16383];
  logic [15:0] ref_mem [0:16383];
  logic        mem_clear;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(16384)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
`ifdef MEM_ACCESS_STATS_EN
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_errs   (stat_errs),
`endif
    .busy      (busy)
  );

  // Memory device: one-cycle registered read, synchronous write.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16384; i++) mem_dev[i] <= '0;
    end else if (mem_we && (mem_addr < 16'h4000)) begin
      mem_dev[mem_addr[13:0]] <= mem_wdata;
    end
    mem_rdata <= mem_dev[mem_addr[13:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one transaction and measures it; the calling test does the comparisons.
  task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic err, output logic [15:0] rd,
                         output int we_cnt, output int we_cyc, output bit tmo);
    int n;
    lat = 0; err = 1'b0; rd = '0; we_cnt = 0; we_cyc = -1; tmo = 1'b0; n = 0;
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 20) begin n++; @(negedge clk); end
    if (!req_ready) begin tmo = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk); #1; req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; if (we_cyc < 0) we_cyc = c; end
      if (rsp_valid) begin lat = c; err = rsp_err; rd = rsp_rdata; break; end
    end
    if (lat == 0) begin tmo = 1'b1; return; end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    $display("txn %s addr=%h wdata=%h lat=%0d err=%b rdata=%h we_cycles=%0d",
             wr ? "ST" : "LD", a, d, lat, err, rd, we_cnt);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk); #1; mem_clear = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    nchk++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    nchk++; if (mem_addr !== 16'h0) begin nerr++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    nchk++; if (mem_wdata !== 16'h0) begin nerr++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nchk++; if (rsp_err !== 1'b0) begin nerr++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    nchk++; if (rsp_rdata !== 16'h0) begin nerr++; $display("FAIL reset_rsp_rdata got=%h exp=0000", rsp_rdata); end
  endtask

  task automatic test_store_load();
    int lat, wc, wy; logic err; logic [15:0] rd; bit tmo;
    run_txn(1'b1, 16'h0010, 16'h1234, lat, err, rd, wc, wy, tmo);
    ref_mem[16'h0010] = 16'h1234;
    nchk++; if (tmo !== 1'b0) begin nerr++; $display("FAIL st_timeout got=%b exp=0", tmo); end
    nchk++; if (lat != 2) begin nerr++; $display("FAIL st_latency got=%0d exp=2", lat); end
    nchk++; if (wc != 1) begin nerr++; $display("FAIL st_we_count got=%0d exp=1", wc); end
    nchk++; if (wy != 1) begin nerr++; $display("FAIL st_we_cycle got=%0d exp=1", wy); end
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL st_err got=%b exp=0", err); end
    nchk++; if (rd !== 16'h0) begin nerr++; $display("FAIL st_rdata got=%h exp=0000", rd); end
    run_txn(1'b0, 16'h0010, 16'h0000, lat, err, rd, wc, wy, tmo);
    nchk++; if (lat != 3) begin nerr++; $display("FAIL ld_latency got=%0d exp=3", lat); end
    nchk++; if (rd !== 16'h1234) begin nerr++; $display("FAIL ld_rdata got=%h exp=1234", rd); end
    nchk++; if (wc != 0) begin nerr++; $display("FAIL ld_we_count got=%0d exp=0", wc); end
  endtask

  task automatic test_boundary();
    int lat, wc, wy; logic err; logic [15:0] rd; bit tmo;
    run_txn(1'b1, 16'h3FFF, 16'hA5A5, lat, err, rd, wc, wy, tmo);
    ref_mem[16'h3FFF] = 16'hA5A5;
    nchk++; if (err !== 1'b0 || wc != 1) begin nerr++; $display("FAIL st_3fff got err=%b we=%0d exp err=0 we=1", err, wc); end
    run_txn(1'b0, 16'h3FFF, 16'h0000, lat, err, rd, wc, wy, tmo);
    nchk++; if (err !== 1'b0) begin nerr++; $display("FAIL ld_3fff_err got=%b exp=0", err); end
    nchk++; if (rd !== ref_mem[16'h3FFF]) begin nerr++; $display("FAIL ld_3fff_rdata got=%h exp=%h", rd, ref_mem[16'h3FFF]); end
    nchk++; if (lat != 3) begin nerr++; $display("FAIL ld_3fff_latency got=%0d exp=3", lat); end
    run_txn(1'b0, 16'h4000, 16'h0000, lat, err, rd, wc, wy, tmo);
    nchk++; if (lat != 1) begin nerr++; $display("FAIL ld_4000_latency got=%0d exp=1", lat); end
    nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL ld_4000_err got=%b exp=1", err); end
    nchk++; if (rd !== 16'h0) begin nerr++; $display("FAIL ld_4000_rdata got=%h exp=0000", rd); end
    nchk++; if (wc != 0) begin nerr++; $display("FAIL ld_4000_we got=%0d exp=0", wc); end
    run_txn(1'b1, 16'hFFFF, 16'h7777, lat, err, rd, wc, wy, tmo);
    nchk++; if (lat != 1) begin nerr++; $display("FAIL st_ffff_latency got=%0d exp=1", lat); end
    nchk++; if (err !== 1'b1) begin nerr++; $display("FAIL st_ffff_err got=%b exp=1", err); end
    nchk++; if (rd !== 16'h0) begin nerr++; $display("FAIL st_ffff_rdata got=%h exp=0000", rd); end
    nchk++; if (wc != 0) begin nerr++; $display("FAIL st_ffff_we got=%0d exp=0", wc); end
  endtask

  task automatic test_random();
    int lat, wc, wy, exp_lat, exp_we; logic err, wr, oor; logic [15:0] rd, a, d, exp_rd; bit tmo;
    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16384, 65535));
      else                           a = 16'($urandom_range(0, 31));
      d = 16'($urandom);
      oor     = (a >= 16'h4000);
      exp_lat = oor ? 1 : (wr ? 2 : 3);
      exp_rd  = (oor || wr) ? 16'h0 : ref_mem[a[13:0]];
      exp_we  = (!oor && wr) ? 1 : 0;
      run_txn(wr, a, d, lat, err, rd, wc, wy, tmo);
      if (!oor && wr) ref_mem[a[13:0]] = d;
      nchk++; if (tmo !== 1'b0) begin nerr++; $display("FAIL rnd_timeout k=%0d got=%b exp=0", k, tmo); end
      nchk++; if (lat != exp_lat) begin nerr++; $display("FAIL rnd_latency k=%0d addr=%h got=%0d exp=%0d", k, a, lat, exp_lat); end
      nchk++; if (err !== oor) begin nerr++; $display("FAIL rnd_err k=%0d addr=%h got=%b exp=%b", k, a, err, oor); end
      nchk++; if (rd !== exp_rd) begin nerr++; $display("FAIL rnd_rdata k=%0d addr=%h got=%h exp=%h", k, a, rd, exp_rd); end
      nchk++; if (wc != exp_we) begin nerr++; $display("FAIL rnd_we k=%0d addr=%h got=%0d exp=%0d", k, a, wc, exp_we); end
    end
  endtask

  task automatic test_backpressure();
    int n, early; logic [15:0] exp_rd;
    exp_rd = ref_mem[16'h0010];
    req_write = 1'b0; req_addr = 16'h0010; req_wdata = '0; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Accept has happened; present the next request and keep it valid throughout.
    req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hBEEF;
    n = 0; early = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      if (req_ready) early++;
      n++; @(negedge clk);
    end
    nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL bp_rsp_timeout got=%b exp=1", rsp_valid); end
    nchk++; if (early != 0) begin nerr++; $display("FAIL bp_ready_while_busy got=%0d exp=0", early); end
    for (int i = 0; i < 5; i++) begin
      nchk++; if (rsp_valid !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid i=%0d got=%b exp=1", i, rsp_valid); end
      nchk++; if (rsp_rdata !== exp_rd || rsp_err !== 1'b0) begin nerr++; $display("FAIL bp_hold_data i=%0d got=%h/%b exp=%h/0", i, rsp_rdata, rsp_err, exp_rd); end
      nchk++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin nerr++; $display("FAIL bp_no_accept i=%0d got ready=%b we=%b exp 0/0", i, req_ready, mem_we); end
      @(negedge clk);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    $display("txn LD addr=0010 backpressured rdata=%h", exp_rd);
    @(negedge clk);
    nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_hs got=%b exp=1", req_ready); end
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    nchk++; if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 16'hBEEF) begin
      nerr++; $display("FAIL bp_second_write got we=%b addr=%h data=%h exp 1/0020/beef", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    nchk++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
      nerr++; $display("FAIL bp_second_rsp got v=%b rd=%h err=%b exp 1/0000/0", rsp_valid, rsp_rdata, rsp_err); end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    ref_mem[16'h0020] = 16'hBEEF;
    $display("txn ST addr=0020 wdata=beef accepted after handshake");
  endtask

  task automatic test_reset_mid();
    int lat, wc, wy, seen; logic err; logic [15:0] rd; bit tmo;
    for (int pass = 0; pass < 2; pass++) begin
      req_write = (pass == 0); req_addr = (pass == 0) ? 16'h0100 : 16'h0010;
      req_wdata = 16'h5555; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      if (pass == 1) begin @(posedge clk); #1; end
      nchk++; if (busy !== 1'b1 || mem_we !== (pass == 0)) begin
        nerr++; $display("FAIL rstmid_pre pass=%0d got busy=%b we=%b", pass, busy, mem_we); end
      reset_n = 1'b0; #1;
      nchk++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL rstmid_we pass=%0d got=%b exp=0", pass, mem_we); end
      nchk++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        nerr++; $display("FAIL rstmid_state pass=%0d got busy=%b v=%b rdy=%b exp 0/0/1", pass, busy, rsp_valid, req_ready); end
      nchk++; if (mem_addr !== 16'h0 || rsp_rdata !== 16'h0) begin
        nerr++; $display("FAIL rstmid_regs pass=%0d got addr=%h rd=%h exp 0/0", pass, mem_addr, rsp_rdata); end
      @(negedge clk); reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin @(negedge clk); if (rsp_valid) seen++; end
      nchk++; if (seen != 0) begin nerr++; $display("FAIL rstmid_no_rsp pass=%0d got=%0d exp=0", pass, seen); end
      nchk++; if (req_ready !== 1'b1) begin nerr++; $display("FAIL rstmid_ready pass=%0d got=%b exp=1", pass, req_ready); end
      @(posedge clk); #1;
      $display("txn %s aborted by reset", (pass == 0) ? "ST" : "LD");
    end
    run_txn(1'b0, 16'h0010, 16'h0000, lat, err, rd, wc, wy, tmo);
    nchk++; if (lat != 3 || rd !== ref_mem[16'h0010]) begin
      nerr++; $display("FAIL rstmid_recover got lat=%0d rd=%h exp 3/%h", lat, rd, ref_mem[16'h0010]); end
  endtask

`ifdef MEM_ACCESS_STATS_EN
  task automatic test_stats();
    int lat, wc, wy; logic err; logic [15:0] rd; bit tmo;
    do_reset();
    for (int i = 0; i < 3; i++) run_txn(1'b0, 16'(16'h0010 + i), 16'h0, lat, err, rd, wc, wy, tmo);
    run_txn(1'b1, 16'h0030, 16'h1111, lat, err, rd, wc, wy, tmo); ref_mem[16'h0030] = 16'h1111;
    run_txn(1'b1, 16'h0031, 16'h2222, lat, err, rd, wc, wy, tmo); ref_mem[16'h0031] = 16'h2222;
    run_txn(1'b0, 16'h5000, 16'h0, lat, err, rd, wc, wy, tmo);
    nchk++; if (stat_reads !== 16'd3) begin nerr++; $display("FAIL stat_reads got=%0d exp=3", stat_reads); end
    nchk++; if (stat_writes !== 16'd2) begin nerr++; $display("FAIL stat_writes got=%0d exp=2", stat_writes); end
    nchk++; if (stat_errs !== 16'd1) begin nerr++; $display("FAIL stat_errs got=%0d exp=1", stat_errs); end
    force dut.u_stat_reads.r_count = 16'hFFFF;
    #1;
    release dut.u_stat_reads.r_count;
    run_txn(1'b0, 16'h0010, 16'h0, lat, err, rd, wc, wy, tmo);
    nchk++; if (stat_reads !== 16'hFFFF) begin nerr++; $display("FAIL stat_reads_sat got=%h exp=ffff", stat_reads); end
    nchk++; if (stat_writes !== 16'd2) begin nerr++; $display("FAIL stat_writes_after got=%0d exp=2", stat_writes); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; mem_clear = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0;
    test_reset();
    test_store_load();
    test_boundary();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef MEM_ACCESS_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Bus initiator for the main memory, the requesting end of its address/data/write-enable interface. It accepts one load or store at a time from the CPU datapath (MAR/MBR side) over a valid/ready request channel. It sequences the memory's one-cycle registered read, or its single write cycle. It returns read data or a completion on a valid/ready response channel. Addresses outside the populated memory range are rejected with an error and never reach the memory.

Parameters:
ADDR_W, 16, request/memory address width
DATA_W, 16, data word width
MEM_DEPTH, 16384, populated words; legal addresses are 0..MEM_DEPTH-1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  load data (0 for stores and errors)
rsp_err  out  1  address out of range
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory registered read data, valid the cycle after the address is sampled
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0. Any in-flight transaction is dropped with no response.
- States: IDLE, RD_ADDR, RD_DATA, WR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch addr, wdata and write.
  - addr >= MEM_DEPTH: go to RESP with err=1, rdata=0, no memory cycle.
  - store: go to WR.
  - load: go to RD_ADDR.
- RD_ADDR: mem_addr=latched addr, mem_we=0; the memory samples the address at the end of this cycle. Go to RD_DATA.
- RD_DATA: capture mem_rdata into rsp_rdata at the end of this cycle. Go to RESP.
- WR: mem_addr/mem_wdata=latched values, mem_we=1 for exactly this one cycle. Go to RESP with rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- Latency, counted from the accept edge to rsp_valid high:
  - load: 3 cycles
  - store: 2 cycles
  - error: 1 cycle
- req_ready=0 in every state except IDLE; no overlap or pipelining. The earliest next accept is the cycle after the response handshake.
- mem_we is driven from registered state and is never high outside WR. mem_addr/mem_wdata hold their last values in IDLE; memory reads in IDLE are harmless and ignored.
- Address compare is unsigned on the full ADDR_W. 0x3FFF is legal; 0x4000..0xFFFF are errors.
- reset_n asserted during WR: mem_we falls asynchronously; the write may be partial in the memory, and this is accepted.

Optional Feature:
MEM_ACCESS_STATS_EN:
- When defined, adds outputs stat_reads, stat_writes and stat_errs, each 16-bit.
- Each counter increments on the response handshake of its transaction type. Errored transactions count only in stat_errs.
- Counters saturate at 0xFFFF and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_access_pkg holds:
  - the state enum typedef (IDLE, RD_ADDR, RD_DATA, WR, RESP)
  - default ADDR_W/DATA_W/MEM_DEPTH constants
  - the STAT_W=16 constant
- One sub-module, sat_counter (width-parameterised saturating increment counter), instantiated three times, only under MEM_ACCESS_STATS_EN.
- FSM and datapath stay in mem_access_ctrl.

Test Plan:
- Reset: hold reset_n=0, release -> req_ready=1, rsp_valid=0, mem_we=0, mem_addr=0, busy=0.
- Store then load, against a 16Ki-word behavioural memory model with registered read:
  - store 0x1234 to 0x0010 -> mem_we=1 for exactly 1 cycle (cycle 1 after accept), rsp_valid at cycle 2, rsp_err=0, rsp_rdata=0
  - load 0x0010 -> rsp_valid at cycle 3, rsp_rdata=0x1234
- Boundary addresses:
  - load 0x3FFF -> rsp_err=0
  - load 0x4000 -> rsp_valid next cycle, rsp_err=1, rsp_rdata=0, mem_we never asserted
  - store to 0xFFFF -> same as the 0x4000 load
- Backpressure: rsp_ready=0 for 5 cycles while req_valid is held with a new request -> response fields stable, req_ready=0, no accept; the new request is accepted the cycle after the rsp handshake.
- Reset mid-op:
  - reset_n low during WR -> mem_we=0 immediately, no rsp_valid afterward, req_ready=1 after release
  - reset_n low during RD_DATA -> same outcome
- With MEM_ACCESS_STATS_EN: 3 loads, 2 stores, 1 out-of-range load -> stat_reads=3, stat_writes=2, stat_errs=1. Force stat_reads to 0xFFFF, then one load -> stays 0xFFFF.
